// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter for the single-port data RAM with port-1 bus lock
// Optional conflict counter enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [15:0]   conflict_cnt
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t     state, state_nxt;
  logic       rr_last, rr_last_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       owner;
  logic       rvalid0, rvalid1;

  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    // Once lock drops, this same cycle is arbitrated with plain round-robin.
    if (state == LOCKED && m1_lock) begin
      if (lock_cnt == LOCK_MAX_C && m0_req) begin
        m0_gnt       = 1'b1;
        lock_cnt_nxt = 8'd0;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
        if (lock_cnt != LOCK_MAX_C)
          lock_cnt_nxt = lock_cnt + 8'd1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end
    end else begin
      if (m0_req && m1_req) begin
        m0_gnt = rr_last;
        m1_gnt = ~rr_last;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
      if (m1_gnt && m1_lock) begin
        state_nxt    = LOCKED;
        lock_cnt_nxt = 8'd1;
      end else begin
        state_nxt    = ARB;
        lock_cnt_nxt = 8'd0;
      end
    end
  end

  always_comb begin
    rr_last_nxt = rr_last;
    if (m1_gnt)
      rr_last_nxt = 1'b1;
    else if (m0_gnt)
      rr_last_nxt = 1'b0;
  end

  assign mem_en    = m0_gnt | m1_gnt;
  assign mem_we    = m0_gnt ? m0_we    : (m1_gnt ? m1_we    : 1'b0);
  assign mem_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
  assign mem_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);
  assign stall     = m0_req & ~m0_gnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ARB;
      rr_last  <= 1'b1;
      lock_cnt <= 8'd0;
      owner    <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvalid0  <= m0_gnt & ~m0_we;
      rvalid1  <= m1_gnt & ~m1_we;
      if (mem_en && !mem_we)
        owner <= m1_gnt;
    end
  end

  assign m0_rvalid = rvalid0;
  assign m1_rvalid = rvalid1;
  assign m0_rdata  = (rvalid0 && !owner) ? mem_rdata : '0;
  assign m1_rdata  = (rvalid1 &&  owner) ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      conflict_q <= 16'd0;
    else if (m0_req && m1_req && conflict_q != 16'hFFFF)
      conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with RAM model and read-data scoreboard
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, stall;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] ram   [1024];
  logic [31:0] model [1024];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt4, exp_sat;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.AW(10), .DW(32), .LOCK_MAX(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
  );

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: retire read data first, then log this cycle's grant.
  always @(negedge CLK) begin
    if (m0_rvalid) begin
      if (q0.size() > 0) chk("sb_m0_rdata", m0_rdata, q0.pop_front());
      else               chk("sb_m0_unexpected", q0.size(), 1);
    end
    if (m1_rvalid) begin
      if (q1.size() > 0) chk("sb_m1_rdata", m1_rdata, q1.pop_front());
      else               chk("sb_m1_unexpected", q1.size(), 1);
    end
    if (mem_en && mem_we) model[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) begin
      if (m1_gnt) q1.push_back(model[mem_addr]);
      else        q0.push_back(model[mem_addr]);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
  endtask

  task automatic do_reset();
    idle();
    RESET_N = 0;
    #1;
    q0.delete();
    q1.delete();
    cyc();
    RESET_N = 1;
  endtask

  initial begin
`ifdef DMEM_ARB_PERF_EN
    exp_cnt4 = 16'd4;
    exp_sat  = 16'hFFFF;
`else
    exp_cnt4 = 16'd0;
    exp_sat  = 16'd0;
`endif
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 32'(i) * 32'h0001_0001;
      model[i] = 32'(i) * 32'h0001_0001;
    end
    ram[10'h010]   = 32'hDEADBEEF;
    model[10'h010] = 32'hDEADBEEF;
    m0_addr = 0; m0_wdata = 0; m1_addr = 0; m1_wdata = 0;
    idle();
    RESET_N = 0;
    #2;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_conflict", conflict_cnt, 0);
    cyc();
    RESET_N = 1;

    // single m0 read
    m0_req = 1; m0_addr = 10'h010;
    #1;
    chk("rd0_gnt", m0_gnt, 1);
    chk("rd0_mem_en", mem_en, 1);
    chk("rd0_mem_we", mem_we, 0);
    chk("rd0_mem_addr", mem_addr, 10'h010);
    chk("rd0_stall", stall, 0);
    cyc();
    idle();
    chk("rd0_rvalid", m0_rvalid, 1);
    chk("rd0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd0_m1_rvalid", m1_rvalid, 0);
    cyc();

    // round-robin conflict from reset
    do_reset();
    m0_req = 1; m0_addr = 10'h010;
    m1_req = 1; m1_addr = 10'h020;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_m0_gnt_%0d", i), m0_gnt, (i % 2 == 0));
      chk($sformatf("rr_m1_gnt_%0d", i), m1_gnt, (i % 2 == 1));
      chk($sformatf("rr_stall_%0d", i), stall, (i % 2 == 1));
      cyc();
    end
    idle();
    chk("rr_m1_rvalid", m1_rvalid, 1);
    chk("rr_m0_rvalid", m0_rvalid, 0);
    chk("rr_conflict", conflict_cnt, exp_cnt4);

    // bounded lock: first slot is a port-0 win with lock asserted (no lock taken)
    m0_req = 1; m0_addr = 10'h011;
    m1_req = 1; m1_addr = 10'h021; m1_lock = 1;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk($sformatf("lk_m0_gnt_%0d", i), m0_gnt, (i == 0 || i == 9));
      chk($sformatf("lk_m1_gnt_%0d", i), m1_gnt, !(i == 0 || i == 9));
      chk($sformatf("lk_stall_%0d", i), stall, !(i == 0 || i == 9));
      cyc();
    end
    idle();
    cyc();

    // m0 write, then read back
    m0_req = 1; m0_we = 1; m0_addr = 10'h3FF; m0_wdata = 32'h12345678;
    #1;
    chk("wr_gnt", m0_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 10'h3FF);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    cyc();
    m0_we = 0;
    chk("wr_no_rvalid", m0_rvalid, 0);
    cyc();
    idle();
    chk("wr_rb_rvalid", m0_rvalid, 1);
    chk("wr_rb_rdata", m0_rdata, 32'h12345678);
    cyc();

    // reset during a pending m1 read
    m1_req = 1; m1_addr = 10'h010;
    #1;
    chk("rp_m1_gnt", m1_gnt, 1);
    @(negedge CLK);
    #1;
    idle();
    RESET_N = 0;
    #1;
    q0.delete();
    q1.delete();
    chk("rp_rvalid_in_rst", m1_rvalid, 0);
    cyc();
    chk("rp_rvalid_after_edge", m1_rvalid, 0);
    RESET_N = 1;
    m0_req = 1; m0_addr = 10'h012;
    m1_req = 1; m1_addr = 10'h022;
    #1;
    chk("rp_first_m0", m0_gnt, 1);
    chk("rp_first_m1", m1_gnt, 0);

    // long conflict run for counter saturation
    for (int i = 0; i < 65540; i++) cyc();
    idle();
    chk("sat_conflict", conflict_cnt, exp_sat);
    cyc();
    cyc();
    chk("sat_hold", conflict_cnt, exp_sat);
    chk("sb_drained", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
